// File: rtl/game_console_pkg.sv
// Shared console constants: session FSM encoding, score width and default step timing.
package game_console_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_MENU  = 2'd0;
  localparam state_t ST_PLAY  = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_OVER  = 2'd3;

  localparam int SCORE_W = 7;

  localparam int DEF_CNT_W       = 24;
  localparam int DEF_BASE_PERIOD = 4000000;
  localparam int DEF_STEP_DEC    = 50000;
  localparam int DEF_MIN_PERIOD  = 1000000;

endpackage

// File: rtl/game_session_ctrl_if.sv
// Button, game-core and status signals between the session controller and the rest of the console.
interface game_session_ctrl_if
  import game_console_pkg::*;
#(
  parameter int NUM_GAMES = 4,
  parameter int SEL_W     = 2
);

  logic                         btn_left;
  logic                         btn_right;
  logic                         btn_start;
  logic [NUM_GAMES-1:0]         game_over_in;
  logic [NUM_GAMES*SCORE_W-1:0] score_in;

  logic [NUM_GAMES-1:0]         game_active;
  logic [SEL_W-1:0]             game_sel;
  logic                         game_btn_left;
  logic                         game_btn_right;
  logic                         step_tick;
  logic                         menu_active;
  logic                         paused;
  logic [SCORE_W-1:0]           high_score;
  logic                         new_record;

  modport master (
    output btn_left, btn_right, btn_start, game_over_in, score_in,
    input  game_active, game_sel, game_btn_left, game_btn_right, step_tick,
           menu_active, paused, high_score, new_record
  );

  modport slave (
    input  btn_left, btn_right, btn_start, game_over_in, score_in,
    output game_active, game_sel, game_btn_left, game_btn_right, step_tick,
           menu_active, paused, high_score, new_record
  );

endinterface

// File: rtl/step_timer.sv
// Movement step timer: score-dependent period with a floor, down-counter with hold, one-cycle tick.
module step_timer
  import game_console_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int STEP_DEC    = DEF_STEP_DEC,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               run,
  input  logic               load,
  input  logic [SCORE_W-1:0] score,
  output logic               tick
);

  localparam int PW = CNT_W + 8;

  logic [PW-1:0]    dec_amount;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clamp before subtracting so a high score can never wrap the period.
  assign dec_amount = PW'(score) * PW'(STEP_DEC);
  assign period = (dec_amount > PW'(BASE_PERIOD - MIN_PERIOD))
                ? CNT_W'(MIN_PERIOD)
                : CNT_W'(BASE_PERIOD) - dec_amount[CNT_W-1:0];

  assign tick = run && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load || tick) begin
      cnt_d = period;
    end else if (run) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= CNT_W'(BASE_PERIOD);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_session_ctrl.sv
// Console session controller: menu/play/pause/over sequencing, button sharing between
// game cores, movement step timing and a per-game high-score bank.
module game_session_ctrl
  import game_console_pkg::*;
#(
  parameter int NUM_GAMES   = 4,
  parameter int SEL_W       = 2,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int STEP_DEC    = DEF_STEP_DEC,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD
) (
  input  logic               clk_pix,
  input  logic               rst,
  game_session_ctrl_if.slave bus
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_GAMES - 1);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 prev_left_q, prev_right_q, prev_start_q;
  logic                 press_left, press_right, press_start;
  logic [NUM_GAMES-1:0] game_active_q, game_active_d;
  logic                 new_record_q, new_record_d;
  logic [NUM_GAMES-1:0] hs_upd;
  logic [SCORE_W-1:0]   hs_q [NUM_GAMES];
  logic [SCORE_W-1:0]   hs_d [NUM_GAMES];
  logic [SCORE_W-1:0]   score_arr [NUM_GAMES];
  logic [SCORE_W-1:0]   score_sel;
  logic                 over_sel;
  logic                 in_game, active_next, record_cycle;
  logic                 timer_run, timer_load;

  assign press_left  = bus.btn_left  & ~prev_left_q;
  assign press_right = bus.btn_right & ~prev_right_q;
  assign press_start = bus.btn_start & ~prev_start_q;
  assign over_sel    = bus.game_over_in[sel_q];
  assign score_sel   = score_arr[sel_q];

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_q <= ST_MENU;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_MENU: begin
        if (press_start) begin
          state_d = ST_PLAY;
        end else if (press_left && !press_right) begin
          sel_d = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
        end else if (press_right && !press_left) begin
          sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
        end
      end
      ST_PLAY: begin
        if (over_sel)         state_d = ST_OVER;
        else if (press_start) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (press_start) state_d = ST_PLAY;
      end
      ST_OVER: begin
        // A cleared game-over flag means the core restarted itself from a passed-through button.
        if (press_start)   state_d = ST_MENU;
        else if (!over_sel) state_d = ST_PLAY;
      end
      default: state_d = ST_MENU;
    endcase
  end

  always_comb begin
    in_game      = (state_q == ST_PLAY) || (state_q == ST_OVER);
    active_next  = (state_d == ST_PLAY) || (state_d == ST_OVER);
    timer_run    = (state_q == ST_PLAY);
    timer_load   = (state_d == ST_PLAY) && (state_q != ST_PLAY) && (state_q != ST_PAUSE);
    record_cycle = (state_q == ST_PLAY) && over_sel;
    new_record_d = |hs_upd;
  end

  for (genvar gi = 0; gi < NUM_GAMES; gi++) begin : g_game
    assign score_arr[gi]     = bus.score_in[gi*SCORE_W +: SCORE_W];
    assign game_active_d[gi] = active_next && (sel_d == SEL_W'(gi));
    assign hs_upd[gi]        = record_cycle && (sel_q == SEL_W'(gi)) && (score_arr[gi] > hs_q[gi]);
    assign hs_d[gi]          = hs_upd[gi] ? score_arr[gi] : hs_q[gi];
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      prev_left_q   <= 1'b0;
      prev_right_q  <= 1'b0;
      prev_start_q  <= 1'b0;
      game_active_q <= '0;
      new_record_q  <= 1'b0;
      for (int i = 0; i < NUM_GAMES; i++) begin
        hs_q[i] <= '0;
      end
    end else begin
      prev_left_q   <= bus.btn_left;
      prev_right_q  <= bus.btn_right;
      prev_start_q  <= bus.btn_start;
      game_active_q <= game_active_d;
      new_record_q  <= new_record_d;
      hs_q          <= hs_d;
    end
  end

  step_timer #(
    .CNT_W       (CNT_W),
    .BASE_PERIOD (BASE_PERIOD),
    .STEP_DEC    (STEP_DEC),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_step_timer (
    .clk   (clk_pix),
    .srst  (rst),
    .run   (timer_run),
    .load  (timer_load),
    .score (score_sel),
    .tick  (bus.step_tick)
  );

  assign bus.game_active    = game_active_q;
  assign bus.game_sel       = sel_q;
  assign bus.game_btn_left  = bus.btn_left  & in_game;
  assign bus.game_btn_right = bus.btn_right & in_game;
  assign bus.menu_active    = (state_q == ST_MENU);
  assign bus.paused         = (state_q == ST_PAUSE);
  assign bus.high_score     = hs_q[sel_q];
  assign bus.new_record     = new_record_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl: a vector table for menu/play/pause flow plus
// hand-written sequences for step timing, high scores and reset.
module tb_game_session_ctrl;

  localparam int NG = 3;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_session_ctrl_if #(.NUM_GAMES(NG), .SEL_W(SW)) io ();

  game_session_ctrl #(
    .NUM_GAMES   (NG),
    .SEL_W       (SW),
    .CNT_W       (24),
    .BASE_PERIOD (20),
    .STEP_DEC    (4),
    .MIN_PERIOD  (8)
  ) dut (
    .clk_pix (clk),
    .rst     (rst),
    .bus     (io)
  );

  typedef struct {
    logic       l, r, s;
    logic [2:0] over;
    logic [1:0] sel;
    logic [2:0] act;
    logic       menu, paused, gbl;
  } vec_t;

  vec_t vt [24];
  int   n_vec = 0;
  int   total = 0;
  int   bad   = 0;

  // Values held by the bench and applied at the next cycle boundary.
  logic       rst_v   = 1'b1;
  logic [2:0] over_v  = 3'b000;
  logic [6:0] score_v = 7'd0;

  task automatic add(input logic l, input logic r, input logic s, input logic [2:0] over,
                     input logic [1:0] sel, input logic [2:0] act,
                     input logic menu, input logic paused, input logic gbl);
    vt[n_vec].l = l; vt[n_vec].r = r; vt[n_vec].s = s; vt[n_vec].over = over;
    vt[n_vec].sel = sel; vt[n_vec].act = act;
    vt[n_vec].menu = menu; vt[n_vec].paused = paused; vt[n_vec].gbl = gbl;
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic l, input logic r, input logic s);
    @(negedge clk);
    io.btn_left     = l;
    io.btn_right    = r;
    io.btn_start    = s;
    io.game_over_in = over_v;
    io.score_in     = {7'd0, score_v, 7'd0};
    rst             = rst_v;
    #1;
  endtask

  task automatic measure(input string name, input int exp);
    int  n;
    logic done;
    n = -1;
    done = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (!done) begin
        cyc(1'b0, 1'b0, 1'b0);
        if (io.step_tick === 1'b1) begin
          n = i;
          done = 1'b1;
        end
      end
    end
    $display("interval %s: %0d cycles", name, n);
    chk(name, 32'(n), 32'(exp));
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst_v = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    io.btn_left = 1'b0; io.btn_right = 1'b0; io.btn_start = 1'b0;
    io.game_over_in = '0; io.score_in = '0;

    //   l     r     s     over    sel    act     menu  paused gbl
    add(1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 2'd2, 3'b000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 3'b000, 2'd2, 3'b000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 2'd1, 3'b000, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'b000, 2'd1, 3'b000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 2'd1, 3'b000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 3'b000, 2'd1, 3'b000, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 3'b010, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 3'b101, 2'd1, 3'b010, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 2'd1, 3'b010, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 3'b000, 2'd1, 3'b010, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 3'b000, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 3'b000, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 3'b000, 2'd1, 3'b000, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 2'd1, 3'b010, 1'b0, 1'b0, 1'b0);

    // Reset state
    do_reset();
    $display("reset: menu=%b sel=%0d hs=%0d", io.menu_active, io.game_sel, io.high_score);
    chk("rst_menu",   32'(io.menu_active), 32'd1);
    chk("rst_sel",    32'(io.game_sel),    32'd0);
    chk("rst_active", 32'(io.game_active), 32'd0);
    chk("rst_tick",   32'(io.step_tick),   32'd0);
    chk("rst_record", 32'(io.new_record),  32'd0);
    chk("rst_hs",     32'(io.high_score),  32'd0);

    for (int i = 0; i < n_vec; i++) begin
      over_v = vt[i].over;
      cyc(vt[i].l, vt[i].r, vt[i].s);
      $display("vec %0d: l=%b r=%b s=%b over=%b -> sel=%0d act=%b menu=%b paused=%b gbl=%b",
               i, vt[i].l, vt[i].r, vt[i].s, vt[i].over, io.game_sel, io.game_active,
               io.menu_active, io.paused, io.game_btn_left);
      chk($sformatf("vec%0d_sel", i),    32'(io.game_sel),      32'(vt[i].sel));
      chk($sformatf("vec%0d_act", i),    32'(io.game_active),   32'(vt[i].act));
      chk($sformatf("vec%0d_menu", i),   32'(io.menu_active),   32'(vt[i].menu));
      chk($sformatf("vec%0d_paused", i), 32'(io.paused),        32'(vt[i].paused));
      chk($sformatf("vec%0d_gbl", i),    32'(io.game_btn_left), 32'(vt[i].gbl));
    end
    over_v = 3'b000;

    // Step timing with game 1
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("sel_before_start", 32'(io.game_sel), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("tick_in_menu", 32'(io.step_tick), 32'd0);
    measure("first_tick", 21);
    chk("active_play", 32'(io.game_active), 32'b010);
    measure("score0", 21);
    score_v = 7'd5;
    measure("score5_prev_reload", 21);
    measure("score5_clamped", 9);
    score_v = 7'd2;
    measure("score2_prev_reload", 9);
    measure("score2", 13);

    // Pause mid-interval: 6 cycles into a 13-cycle interval
    for (int j = 1; j <= 5; j++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk($sformatf("pre_pause_tick%0d", j), 32'(io.step_tick), 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 10; j++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("pause_paused%0d", j), 32'(io.paused),        32'd1);
      chk($sformatf("pause_active%0d", j), 32'(io.game_active),   32'd0);
      chk($sformatf("pause_tick%0d", j),   32'(io.step_tick),     32'd0);
      chk($sformatf("pause_gbl%0d", j),    32'(io.game_btn_left), 32'd0);
    end
    $display("pause: held 10 cycles");
    cyc(1'b0, 1'b0, 1'b1);
    measure("resume", 7);

    // First game over with score 3 sets a record
    over_v = 3'b010;
    score_v = 7'd3;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    $display("over1: act=%b hs=%0d rec=%b", io.game_active, io.high_score, io.new_record);
    chk("over1_active", 32'(io.game_active), 32'b010);
    chk("over1_menu",   32'(io.menu_active), 32'd0);
    chk("over1_paused", 32'(io.paused),      32'd0);
    chk("over1_hs",     32'(io.high_score),  32'd3);
    chk("over1_record", 32'(io.new_record),  32'd1);
    chk("over1_tick",   32'(io.step_tick),   32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("over1_record_once", 32'(io.new_record), 32'd0);
    chk("over1_hs_held",     32'(io.high_score), 32'd3);
    over_v = 3'b000;
    cyc(1'b0, 1'b0, 1'b0);
    chk("restart_active", 32'(io.game_active), 32'b010);
    measure("restart_reload", 9);

    // Equal score does not set a record
    over_v = 3'b010;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    $display("over2: act=%b hs=%0d rec=%b", io.game_active, io.high_score, io.new_record);
    chk("over2_record", 32'(io.new_record),  32'd0);
    chk("over2_hs",     32'(io.high_score),  32'd3);
    chk("over2_active", 32'(io.game_active), 32'b010);
    cyc(1'b0, 1'b0, 1'b0);
    chk("over2_record_late", 32'(io.new_record), 32'd0);

    // Start in OVER wins over the still-set game-over flag
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    $display("back to menu: menu=%b sel=%0d hs=%0d", io.menu_active, io.game_sel, io.high_score);
    chk("menu_again",   32'(io.menu_active), 32'd1);
    chk("menu_sel",     32'(io.game_sel),    32'd1);
    chk("menu_active0", 32'(io.game_active), 32'd0);
    chk("menu_hs1",     32'(io.high_score),  32'd3);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("menu_sel0", 32'(io.game_sel),   32'd0);
    chk("menu_hs0",  32'(io.high_score), 32'd0);

    // Game over and start in the same PLAY cycle -> OVER, not PAUSE
    over_v = 3'b000;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("sel_back1", 32'(io.game_sel), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("replay_active", 32'(io.game_active), 32'b010);
    chk("replay_menu",   32'(io.menu_active), 32'd0);
    over_v = 3'b010;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    $display("over+start: paused=%b act=%b", io.paused, io.game_active);
    chk("overstart_paused", 32'(io.paused),      32'd0);
    chk("overstart_active", 32'(io.game_active), 32'b010);
    chk("overstart_record", 32'(io.new_record),  32'd0);

    // Reset in PLAY
    over_v = 3'b000;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("preclr_active", 32'(io.game_active), 32'b010);
    do_reset();
    $display("mid-play reset: menu=%b sel=%0d hs=%0d", io.menu_active, io.game_sel, io.high_score);
    chk("clr_menu",   32'(io.menu_active), 32'd1);
    chk("clr_sel",    32'(io.game_sel),    32'd0);
    chk("clr_hs",     32'(io.high_score),  32'd0);
    chk("clr_active", 32'(io.game_active), 32'd0);
    chk("clr_paused", 32'(io.paused),      32'd0);
    chk("clr_tick",   32'(io.step_tick),   32'd0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clr_sel1", 32'(io.game_sel),   32'd1);
    chk("clr_hs1",  32'(io.high_score), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_session_ctrl.md
Name: game_session_ctrl

Overview:
Console-level session controller that sequences the game cores (snake and siblings) and shares the button inputs between them. It runs a menu, pause and game-over state machine, asserts exactly one game_active at a time and gates the buttons to that game. It also generates the movement step tick, whose period shortens with score, and keeps a per-game high score. It sits between the board button inputs and the game cores, in the clk_pix domain.

Parameters:
NUM_GAMES, 4, number of game cores; a power of two is not required, minimum 2
SEL_W, 2, width of game_sel; must satisfy 2**SEL_W >= NUM_GAMES
CNT_W, 24, step counter width
BASE_PERIOD, 4000000, step period in clk_pix cycles at score 0
STEP_DEC, 50000, period reduction per score point
MIN_PERIOD, 1000000, floor of the step period

Ports:
clk_pix  in  1  pixel clock; the only clock
rst  in  1  synchronous, active-high reset
btn_left  in  1  raw level, already synchronised
btn_right  in  1  raw level, already synchronised
btn_start  in  1  raw level, already synchronised
game_over_in  in  NUM_GAMES  per-game game-over flag
score_in  in  NUM_GAMES*7  per-game score; slice g is bits [7g+6:7g]
game_active  out  NUM_GAMES  one-hot or zero enable to the game cores
game_sel  out  SEL_W  currently selected game index
game_btn_left  out  1  btn_left gated to the active game
game_btn_right  out  1  btn_right gated to the active game
step_tick  out  1  one-cycle pulse per movement step
menu_active  out  1  high in the MENU state
paused  out  1  high in the PAUSE state
high_score  out  7  best score recorded for game_sel
new_record  out  1  one-cycle pulse when high_score is updated

Behaviour:
- Reset (synchronous, active-high) sets the following:
  - state MENU, game_sel 0, all high-score registers 0
  - step counter loaded with BASE_PERIOD
  - button history registers 0
  - step_tick 0, new_record 0
- Edge detection: press_x = btn_x & ~prev_x. The prev registers update every cycle, in every state.
- game_active[game_sel] = 1 in PLAY and OVER; all bits are 0 in MENU and PAUSE. game_active is registered from state.
- game_btn_left and game_btn_right = btn level AND (state is PLAY or OVER). They are 0 otherwise.
- menu_active and paused are decoded from the registered state.
- FSM transitions:
  - MENU:
    - press_left alone: game_sel becomes game_sel-1, wrapping from 0 to NUM_GAMES-1.
    - press_right alone: game_sel becomes game_sel+1, wrapping from NUM_GAMES-1 to 0.
    - press_left and press_right in the same cycle: game_sel is unchanged.
    - press_start: go to PLAY and load the step counter with the current period. Left/right in that same cycle are ignored.
  - PLAY:
    - game_over_in[game_sel] = 1: go to OVER. This has priority over press_start.
    - press_start: go to PAUSE.
  - PAUSE:
    - press_start: go to PLAY. The step counter resumes from its held value.
    - All other inputs are ignored.
  - OVER:
    - press_start: go to MENU. game_sel is kept.
    - game_over_in[game_sel] falling to 0 (the core restarted itself from a passed-through button): go to PLAY and reload the step counter.
    - If both happen in the same cycle, press_start wins.
- High score update, on the PLAY to OVER transition cycle:
  - If score_in[game_sel] > hs[game_sel], then hs[game_sel] is updated and new_record pulses 1 the next cycle.
  - Equal scores do not update.
- high_score = hs[game_sel], combinational.
- Step period:
  - p = BASE_PERIOD - score*STEP_DEC, computed at CNT_W+8 bits, where score = score_in[game_sel].
  - If score*STEP_DEC > BASE_PERIOD - MIN_PERIOD, then p = MIN_PERIOD. The result never underflows.
  - The period is sampled only at counter reload.
- Step counter:
  - Decrements only in PLAY; it holds in PAUSE, MENU and OVER.
  - When it is 0 in PLAY: step_tick = 1 for that cycle and the counter reloads with p. The tick interval is therefore p+1 cycles.
  - step_tick is 0 outside PLAY.
- game_over_in bits of non-selected games are ignored.
- score_in is assumed stable relative to clk_pix. No handshake is required.

Decomposition:
- Package game_console_pkg holds:
  - state encoding localparams (MENU=0, PLAY=1, PAUSE=2, OVER=3)
  - score width 7
  - default period constants
- One sub-module, step_timer: period computation with clamp, down-counter, tick and hold enable. It is reused by the other game cores.
- The FSM, button edge detection and high-score bank stay in the top module.

Test Plan:
All scenarios use small parameters: NUM_GAMES=3, BASE_PERIOD=20, STEP_DEC=4, MIN_PERIOD=8.
- Reset, then press_left in MENU -> game_sel=2 and game_active=000. Then press_right twice -> game_sel=1. Simultaneous left+right -> game_sel stays 1.
- With game_sel=1, press_start -> game_active=010 the next cycle. With score 0 the first step_tick arrives 21 cycles after the start press cycle, and ticks repeat every 21 cycles.
- score_in[1]=5 -> reloaded period clamps to 8, giving ticks every 9 cycles. score_in[1]=2 -> period 12, giving ticks every 13 cycles.
- In PLAY, press_start -> paused=1, game_active=000, no ticks, game_btn_left=0 while btn_left=1. press_start again -> tick interval resumes from the held count.
- score_in[1]=3, then game_over_in[1]=1 -> OVER, high_score=3, new_record pulses once. A second over with score 3 -> no pulse. game_over_in[1] dropping -> PLAY.
- game_over_in[1] and press_start asserted in the same PLAY cycle -> OVER, not PAUSE. Reset asserted mid-PLAY -> MENU, game_sel=0, high_score=0.
